// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - multi-channel fixed-latency memory responder
// Shared word storage; each channel runs its own IDLE/WAIT/RESP handshake FSM.
module mem_responder #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int CHANNELS  = 4,
  parameter int LATENCY   = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [CHANNELS-1:0]                  read_valid,
  input  logic [CHANNELS-1:0][ADDR_BITS-1:0]   read_address,
  output logic [CHANNELS-1:0]                  read_ready,
  output logic [CHANNELS-1:0][DATA_BITS-1:0]   read_data,
  input  logic [CHANNELS-1:0]                  write_valid,
  input  logic [CHANNELS-1:0][ADDR_BITS-1:0]   write_address,
  input  logic [CHANNELS-1:0][DATA_BITS-1:0]   write_data,
  output logic [CHANNELS-1:0]                  write_ready,
  input  logic                                 init_we,
  input  logic [ADDR_BITS-1:0]                 init_addr,
  input  logic [DATA_BITS-1:0]                 init_data,
  output logic [31:0]                          req_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);
  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DATA_BITS-1:0]                 r_mem [DEPTH];
  logic [1:0]                           r_state [CHANNELS];
  logic [3:0]                           r_cnt [CHANNELS];
  logic [ADDR_BITS-1:0]                 r_addr [CHANNELS];
  logic [DATA_BITS-1:0]                 r_wdata [CHANNELS];
  logic [CHANNELS-1:0]                  r_op_wr;
  logic [CHANNELS-1:0]                  r_rd_ready;
  logic [CHANNELS-1:0]                  r_wr_ready;
  logic [CHANNELS-1:0][DATA_BITS-1:0]   r_rdata;
  logic [31:0]                          r_req_count;

  logic [CHANNELS-1:0]                  w_accept;
  logic [CHANNELS-1:0]                  w_enter;
  logic [CHANNELS-1:0]                  w_enter_wr;
  logic [ADDR_BITS-1:0]                 w_acc_addr [CHANNELS];
  logic [ADDR_BITS-1:0]                 w_enter_addr [CHANNELS];
  logic [DATA_BITS-1:0]                 w_enter_data [CHANNELS];
  logic [31:0]                          w_acc_num;

  // With LATENCY=1 the RESP entry happens on the accept edge, so use live inputs.
  always_comb begin
    w_accept   = '0;
    w_enter    = '0;
    w_enter_wr = '0;
    w_acc_num  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_acc_addr[c]   = write_valid[c] ? write_address[c] : read_address[c];
      w_enter_addr[c] = r_addr[c];
      w_enter_data[c] = r_wdata[c];
      w_accept[c]     = (r_state[c] == S_IDLE) && (write_valid[c] || read_valid[c]);
      if (LATENCY == 1) begin
        w_enter[c]      = w_accept[c];
        w_enter_wr[c]   = write_valid[c];
        w_enter_addr[c] = w_acc_addr[c];
        w_enter_data[c] = write_data[c];
      end else begin
        w_enter[c]    = (r_state[c] == S_WAIT) && (r_cnt[c] == 4'd1);
        w_enter_wr[c] = r_op_wr[c];
      end
      w_acc_num = w_acc_num + 32'(w_accept[c]);
    end
  end

  // Ascending loop lets the highest channel win; init_we is written last and beats all.
  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (!reset && w_enter[c] && w_enter_wr[c])
        r_mem[w_enter_addr[c]] <= w_enter_data[c];
    end
    if (init_we)
      r_mem[init_addr] <= init_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_state[c] <= S_IDLE;
        r_cnt[c]   <= '0;
        r_addr[c]  <= '0;
        r_wdata[c] <= '0;
      end
      r_op_wr     <= '0;
      r_rd_ready  <= '0;
      r_wr_ready  <= '0;
      r_rdata     <= '0;
      r_req_count <= '0;
    end else begin
      r_req_count <= r_req_count + w_acc_num;
      for (int c = 0; c < CHANNELS; c++) begin
        case (r_state[c])
          S_IDLE: begin
            if (w_accept[c]) begin
              r_op_wr[c] <= write_valid[c];
              r_addr[c]  <= w_acc_addr[c];
              r_wdata[c] <= write_data[c];
              r_cnt[c]   <= CNT_LOAD;
              r_state[c] <= (LATENCY == 1) ? S_RESP : S_WAIT;
            end
          end
          S_WAIT: begin
            r_cnt[c] <= r_cnt[c] - 4'd1;
            if (r_cnt[c] == 4'd1)
              r_state[c] <= S_RESP;
          end
          S_RESP: begin
            if ((r_op_wr[c] && !write_valid[c]) || (!r_op_wr[c] && !read_valid[c])) begin
              r_state[c]    <= S_IDLE;
              r_rd_ready[c] <= 1'b0;
              r_wr_ready[c] <= 1'b0;
            end
          end
          default: r_state[c] <= S_IDLE;
        endcase
        // Storage is read before this edge's commits land, giving the pre-write value.
        if (w_enter[c]) begin
          if (w_enter_wr[c]) begin
            r_wr_ready[c] <= 1'b1;
          end else begin
            r_rd_ready[c] <= 1'b1;
            r_rdata[c]    <= r_mem[w_enter_addr[c]];
          end
        end
      end
    end
  end

  assign read_ready  = r_rd_ready;
  assign write_ready = r_wr_ready;
  assign read_data   = r_rdata;
  assign req_count   = r_req_count;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed bench for mem_responder
// Instance a uses LATENCY=2, instance b uses LATENCY=1.
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             a_reset, a_iwe;
  logic [3:0]       a_rv, a_rr, a_wv, a_wr;
  logic [3:0][7:0]  a_ra, a_rd, a_wa, a_wd;
  logic [7:0]       a_ia, a_id;
  logic [31:0]      a_cnt;

  logic             b_reset, b_iwe;
  logic [3:0]       b_rv, b_rr, b_wv, b_wr;
  logic [3:0][7:0]  b_ra, b_rd, b_wa, b_wd;
  logic [7:0]       b_ia, b_id;
  logic [31:0]      b_cnt;

  int checks = 0;
  int errors = 0;

  mem_responder #(.ADDR_BITS(8), .DATA_BITS(8), .CHANNELS(4), .LATENCY(2)) u_a (
    .clk(clk), .reset(a_reset),
    .read_valid(a_rv), .read_address(a_ra), .read_ready(a_rr), .read_data(a_rd),
    .write_valid(a_wv), .write_address(a_wa), .write_data(a_wd), .write_ready(a_wr),
    .init_we(a_iwe), .init_addr(a_ia), .init_data(a_id), .req_count(a_cnt)
  );

  mem_responder #(.ADDR_BITS(8), .DATA_BITS(8), .CHANNELS(4), .LATENCY(1)) u_b (
    .clk(clk), .reset(b_reset),
    .read_valid(b_rv), .read_address(b_ra), .read_ready(b_rr), .read_data(b_rd),
    .write_valid(b_wv), .write_address(b_wa), .write_data(b_wd), .write_ready(b_wr),
    .init_we(b_iwe), .init_addr(b_ia), .init_data(b_id), .req_count(b_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic init_a(input logic [7:0] addr, input logic [7:0] data);
    a_iwe = 1'b1; a_ia = addr; a_id = data;
    tick();
    a_iwe = 1'b0;
  endtask

  task automatic init_b(input logic [7:0] addr, input logic [7:0] data);
    b_iwe = 1'b1; b_ia = addr; b_id = data;
    tick();
    b_iwe = 1'b0;
  endtask

  initial begin
    a_reset = 1'b1; a_iwe = 1'b0; a_ia = '0; a_id = '0;
    a_rv = '0; a_ra = '0; a_wv = '0; a_wa = '0; a_wd = '0;
    b_reset = 1'b1; b_iwe = 1'b0; b_ia = '0; b_id = '0;
    b_rv = '0; b_ra = '0; b_wv = '0; b_wa = '0; b_wd = '0;
    tick();

    // preload while held in reset
    init_a(8'd5, 8'h3C);
    init_a(8'd9, 8'h00);
    init_a(8'd2, 8'h07);
    init_a(8'd4, 8'h00);
    init_a(8'd7, 8'h00);
    init_b(8'd10, 8'hB0);
    init_b(8'd11, 8'hB1);
    init_b(8'd12, 8'hB2);
    init_b(8'd13, 8'hB3);

    chk("rst_read_ready", 32'(a_rr), 32'h0);
    chk("rst_write_ready", 32'(a_wr), 32'h0);
    chk("rst_read_data", a_rd, 32'h0);
    chk("rst_req_count", a_cnt, 32'h0);
    a_reset = 1'b0;

    // single read, latency 2, address change while pending is ignored
    a_rv[0] = 1'b1; a_ra[0] = 8'd5;
    tick();
    chk("rd_not_ready_k", 32'(a_rr), 32'h0);
    a_ra[0] = 8'd9;
    tick();
    chk("rd_ready_k1", 32'(a_rr), 32'h1);
    chk("rd_data_k1", 32'(a_rd[0]), 32'h3C);
    a_rv[0] = 1'b0;
    tick();
    chk("rd_ready_drop", 32'(a_rr), 32'h0);
    chk("rd_data_hold", 32'(a_rd[0]), 32'h3C);
    chk("rd_req_count", a_cnt, 32'd1);

    a_reset = 1'b1; tick(); a_reset = 1'b0;

    // ch1 write then ch2 read of the same address
    a_wv[1] = 1'b1; a_wa[1] = 8'd9; a_wd[1] = 8'hA5;
    tick();
    chk("wr_not_ready_k", 32'(a_wr), 32'h0);
    tick();
    chk("wr_ready_k1", 32'(a_wr), 32'h2);
    a_wv[1] = 1'b0;
    tick();
    chk("wr_ready_drop", 32'(a_wr), 32'h0);
    a_rv[2] = 1'b1; a_ra[2] = 8'd9;
    tick(); tick();
    chk("wr_rd_ready", 32'(a_rr), 32'h4);
    chk("wr_rd_data", 32'(a_rd[2]), 32'hA5);
    a_rv[2] = 1'b0;
    tick();
    chk("wr_rd_req_count", a_cnt, 32'd2);

    // same-edge writes to one address, highest channel wins
    a_wv = 4'b1001; a_wa[0] = 8'd7; a_wa[3] = 8'd7; a_wd[0] = 8'h11; a_wd[3] = 8'h22;
    tick(); tick();
    chk("dual_wr_ready", 32'(a_wr), 32'h9);
    a_wv = '0;
    tick();
    a_rv[1] = 1'b1; a_ra[1] = 8'd7;
    tick(); tick();
    chk("dual_wr_winner", 32'(a_rd[1]), 32'h22);
    a_rv[1] = 1'b0;
    tick();

    // read and write both requested: write goes first
    a_rv[0] = 1'b1; a_wv[0] = 1'b1; a_ra[0] = 8'd4; a_wa[0] = 8'd4; a_wd[0] = 8'h5A;
    tick(); tick();
    chk("rw_write_first", 32'(a_wr), 32'h1);
    chk("rw_no_read_yet", 32'(a_rr), 32'h0);
    a_wv[0] = 1'b0;
    tick();
    chk("rw_write_drop", 32'(a_wr), 32'h0);
    tick();
    chk("rw_read_wait", 32'(a_rr), 32'h0);
    tick();
    chk("rw_read_ready", 32'(a_rr), 32'h1);
    chk("rw_read_data", 32'(a_rd[0]), 32'h5A);
    a_rv[0] = 1'b0;
    tick();

    // read and write of one word committing on the same edge: read sees old value
    a_wv[0] = 1'b1; a_wa[0] = 8'd5; a_wd[0] = 8'h77;
    a_rv[1] = 1'b1; a_ra[1] = 8'd5;
    tick(); tick();
    chk("same_edge_wr_ready", 32'(a_wr), 32'h1);
    chk("same_edge_rd_ready", 32'(a_rr), 32'h2);
    chk("same_edge_old_data", 32'(a_rd[1]), 32'h3C);
    a_wv = '0; a_rv = '0;
    tick();
    a_rv[2] = 1'b1; a_ra[2] = 8'd5;
    tick(); tick();
    chk("same_edge_new_data", 32'(a_rd[2]), 32'h77);
    a_rv = '0;
    tick();

    // reset during WAIT of a write drops it
    a_reset = 1'b1; tick(); a_reset = 1'b0;
    a_wv[0] = 1'b1; a_wa[0] = 8'd2; a_wd[0] = 8'h99;
    tick();
    a_reset = 1'b1;
    tick();
    chk("mid_rst_write_ready", 32'(a_wr), 32'h0);
    chk("mid_rst_read_ready", 32'(a_rr), 32'h0);
    chk("mid_rst_req_count", a_cnt, 32'h0);
    a_reset = 1'b0; a_wv = '0;
    a_rv[0] = 1'b1; a_ra[0] = 8'd2;
    tick(); tick();
    chk("mid_rst_storage", 32'(a_rd[0]), 32'h07);
    a_rv = '0;
    tick();

    // latency 1, all four channels read on one edge
    b_reset = 1'b0;
    b_rv = 4'hF;
    b_ra[0] = 8'd10; b_ra[1] = 8'd11; b_ra[2] = 8'd12; b_ra[3] = 8'd13;
    tick();
    chk("lat1_ready", 32'(b_rr), 32'hF);
    chk("lat1_data0", 32'(b_rd[0]), 32'hB0);
    chk("lat1_data1", 32'(b_rd[1]), 32'hB1);
    chk("lat1_data2", 32'(b_rd[2]), 32'hB2);
    chk("lat1_data3", 32'(b_rd[3]), 32'hB3);
    chk("lat1_req_count", b_cnt, 32'd4);
    b_rv = '0;
    tick();
    chk("lat1_ready_drop", 32'(b_rr), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
